// File: rtl/flipflop_chain_controller_pkg.sv
// Shared encodings for the flip-flop chain controller: FSM states and requester IDs.
package flipflop_chain_controller_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/flipflop_chain_arbiter.sv
// Two-way round-robin select; a tie goes to whoever was not served last.
module flipflop_chain_arbiter
  import flipflop_chain_controller_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_take,
  output logic o_valid,
  output logic o_winner
);

  logic r_last;
  logic w_winner;

  always_comb begin
    w_winner = REQ_A;
    if (i_req_a && i_req_b) w_winner = ~r_last;
    else if (i_req_b)       w_winner = REQ_B;
  end

  // Reset to B so that A wins the very first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  r_last <= REQ_B;
    else if (i_take && o_valid)    r_last <= w_winner;
  end

  assign o_valid  = i_req_a | i_req_b;
  assign o_winner = w_winner;

endmodule

// File: rtl/flipflop_chain_controller.sv
// Grants one of two requesters, clears the flip-flop chain, then shifts the
// captured word in MSB-first and pulses done once the chain holds it.
module flipflop_chain_controller
  import flipflop_chain_controller_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic             clockpulse,
  input  logic             clear_,
  input  logic             request_a,
  input  logic             request_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             grant_a,
  output logic             grant_b,
  output logic             busy,
  output logic             chain_clear,
  output logic             chain_data,
  output logic             chain_valid,
  output logic             done
);

  state_t               r_state, w_next;
  logic [CNT_WIDTH-1:0] r_count, w_idx;
  logic [WIDTH-1:0]     r_word, w_word_sh;
  logic                 r_grant_a, r_grant_b, r_busy, r_chain_clear;
  logic                 r_chain_data, r_chain_valid, r_done;
  logic                 w_take, w_req_valid, w_winner;

  flipflop_chain_arbiter u_arb (
    .i_clk    (clockpulse),
    .i_rst_n  (clear_),
    .i_req_a  (request_a),
    .i_req_b  (request_b),
    .i_take   (w_take),
    .o_valid  (w_req_valid),
    .o_winner (w_winner)
  );

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    case (r_state)
      IDLE: if (w_req_valid) begin
        w_next = CLEAR;
        w_take = 1'b1;
      end
      CLEAR:   w_next = SHIFT;
      SHIFT:   if (r_count == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_count is the index of the bit currently on chain_data; w_word_sh[0] is the next one.
  assign w_idx     = r_count - CNT_WIDTH'(1);
  assign w_word_sh = r_word >> w_idx;

  // Outputs are decoded from the next state so they appear registered in the state's own cycle.
  always_ff @(posedge clockpulse or negedge clear_) begin
    if (!clear_) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_word        <= '0;
      r_grant_a     <= 1'b0;
      r_grant_b     <= 1'b0;
      r_busy        <= 1'b0;
      r_chain_clear <= 1'b0;
      r_chain_data  <= 1'b0;
      r_chain_valid <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_grant_a     <= w_take && (w_winner == REQ_A);
      r_grant_b     <= w_take && (w_winner == REQ_B);
      r_busy        <= (w_next != IDLE);
      r_chain_clear <= w_take;
      r_chain_valid <= (w_next == SHIFT);
      r_done        <= (w_next == DONE);

      if (w_take) begin
        r_word  <= (w_winner == REQ_B) ? data_b : data_a;
        r_count <= CNT_WIDTH'(WIDTH - 1);
      end else if (r_state == SHIFT && r_count != '0) begin
        r_count <= w_idx;
      end

      if (r_state == CLEAR)                         r_chain_data <= r_word[WIDTH-1];
      else if (r_state == SHIFT && r_count != '0)   r_chain_data <= w_word_sh[0];
      else                                          r_chain_data <= 1'b0;
    end
  end

  assign grant_a     = r_grant_a;
  assign grant_b     = r_grant_b;
  assign busy        = r_busy;
  assign chain_clear = r_chain_clear;
  assign chain_data  = r_chain_data;
  assign chain_valid = r_chain_valid;
  assign done        = r_done;

endmodule

// File: tb/tb_flipflop_chain_controller.sv
// Bench for flipflop_chain_controller: 4-bit and 8-bit instances driving modelled chains.
module tb_flipflop_chain_controller;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef struct packed {
    logic       who;
    logic [7:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic clear_ = 1'b0;

  logic       request_a = 1'b0, request_b = 1'b0;
  logic [3:0] data_a = '0, data_b = '0;
  logic       grant_a, grant_b, busy, chain_clear, chain_data, chain_valid, done;

  logic       request_a8 = 1'b0, request_b8 = 1'b0;
  logic [7:0] data_a8 = '0, data_b8 = '0;
  logic       grant_a8, grant_b8, busy8, chain_clear8, chain_data8, chain_valid8, done8;

  logic [3:0] chain4 = '0;
  logic [7:0] chain8 = '0;
  logic [6:0] o4, o8;

  always #5 clk = ~clk;

  flipflop_chain_controller #(.WIDTH(4), .CNT_WIDTH(3)) dut (
    .clockpulse(clk), .clear_(clear_),
    .request_a(request_a), .request_b(request_b),
    .data_a(data_a), .data_b(data_b),
    .grant_a(grant_a), .grant_b(grant_b), .busy(busy),
    .chain_clear(chain_clear), .chain_data(chain_data),
    .chain_valid(chain_valid), .done(done)
  );

  flipflop_chain_controller #(.WIDTH(8), .CNT_WIDTH(4)) dut8 (
    .clockpulse(clk), .clear_(clear_),
    .request_a(request_a8), .request_b(request_b8),
    .data_a(data_a8), .data_b(data_b8),
    .grant_a(grant_a8), .grant_b(grant_b8), .busy(busy8),
    .chain_clear(chain_clear8), .chain_data(chain_data8),
    .chain_valid(chain_valid8), .done(done8)
  );

  assign o4 = {grant_a, grant_b, busy, chain_clear, chain_data, chain_valid, done};
  assign o8 = {grant_a8, grant_b8, busy8, chain_clear8, chain_data8, chain_valid8, done8};

  // Chains of flipflop_d cells: cell 0 takes chain_data, each cell feeds the next.
  always @(posedge clk) begin
    if (chain_clear)  chain4 <= '0;
    else              chain4 <= {chain4[2:0], chain_data};
    if (chain_clear8) chain8 <= '0;
    else              chain8 <= {chain8[6:0], chain_data8};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (o4 !== 7'b0) begin errors++; $display("FAIL reset_outs4 got %b exp %b", o4, 7'b0); end
    checks++;
    if (o8 !== 7'b0) begin errors++; $display("FAIL reset_outs8 got %b exp %b", o8, 7'b0); end
    clear_ = 1'b1;
    tick();
    checks++;
    if (o4 !== 7'b0) begin errors++; $display("FAIL idle_outs4 got %b exp %b", o4, 7'b0); end
  endtask

  task automatic test_a_alone();
    exp_t e;
    logic [6:0] x;
    data_a = 4'b1011; request_a = 1'b1;
    exp_q.push_back('{REQ_A, 8'h0B});
    tick();
    checks++;
    if (o4 !== 7'b1011000) begin errors++; $display("FAIL a_clear_cycle got %b exp %b", o4, 7'b1011000); end
    request_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      x = {4'b0010, exp_q[0].word[3-i], 2'b10};
      checks++;
      if (o4 !== x) begin errors++; $display("FAIL a_shift%0d got %b exp %b", i, o4, x); end
    end
    tick();
    checks++;
    if (o4 !== 7'b0010001) begin errors++; $display("FAIL a_done got %b exp %b", o4, 7'b0010001); end
    e = exp_q.pop_front();
    checks++;
    if (chain4 !== e.word[3:0]) begin errors++; $display("FAIL a_chain got %b exp %b", chain4, e.word[3:0]); end
    tick();
    checks++;
    if (o4 !== 7'b0) begin errors++; $display("FAIL a_idle got %b exp %b", o4, 7'b0); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    clear_ = 1'b0; #2; clear_ = 1'b1;
    data_a = 4'h3; data_b = 4'hC; request_a = 1'b1; request_b = 1'b1;
    exp_q.push_back('{REQ_A, 8'h03});
    exp_q.push_back('{REQ_B, 8'h0C});
    exp_q.push_back('{REQ_A, 8'h03});
    for (int t = 0; t < 3; t++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({grant_a, grant_b} !== (e.who ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL b2b_grant%0d got %b exp %b", t, {grant_a, grant_b}, (e.who ? 2'b01 : 2'b10));
      end
      if (t == 2) begin request_a = 1'b0; request_b = 1'b0; end
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (done !== 1'b1 || chain4 !== e.word[3:0]) begin
        errors++; $display("FAIL b2b_done%0d got done=%b chain=%b exp done=1 chain=%b", t, done, chain4, e.word[3:0]);
      end
      tick();
      checks++;
      if (o4 !== 7'b0) begin errors++; $display("FAIL b2b_idle%0d got %b exp %b", t, o4, 7'b0); end
    end
  endtask

  task automatic test_ignore_b();
    exp_t e;
    logic seen_b;
    seen_b = 1'b0;
    data_a = 4'h5; request_a = 1'b1;
    exp_q.push_back('{REQ_A, 8'h05});
    tick();
    request_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen_b |= grant_b;
      if (i == 1) begin request_b = 1'b1; data_b = 4'hF; end
      if (i == 2) request_b = 1'b0;
    end
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || chain4 !== e.word[3:0]) begin
      errors++; $display("FAIL ignb_done got done=%b chain=%b exp done=1 chain=%b", done, chain4, e.word[3:0]);
    end
    tick(); seen_b |= grant_b;
    tick(); seen_b |= grant_b;
    checks++;
    if (seen_b !== 1'b0) begin errors++; $display("FAIL ignb_grant_b got %b exp %b", seen_b, 1'b0); end
  endtask

  task automatic test_data_change();
    exp_t e;
    data_a = 4'hF; request_a = 1'b1;
    exp_q.push_back('{REQ_A, 8'h0F});
    tick();
    data_a = 4'h0; request_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({chain_valid, chain_data} !== 2'b11) begin
        errors++; $display("FAIL dchg_bit%0d got %b exp %b", i, {chain_valid, chain_data}, 2'b11);
      end
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || chain4 !== e.word[3:0]) begin
      errors++; $display("FAIL dchg_done got done=%b chain=%b exp done=1 chain=%b", done, chain4, e.word[3:0]);
    end
    tick();
  endtask

  task automatic test_async_clear();
    exp_t e;
    data_a = 4'hA; request_a = 1'b1;
    tick();
    request_a = 1'b0;
    tick(); tick();
    #3 clear_ = 1'b0;
    #1;
    checks++;
    if (o4 !== 7'b0) begin errors++; $display("FAIL aclr_outs got %b exp %b", o4, 7'b0); end
    #2 clear_ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (o4 !== 7'b0) begin errors++; $display("FAIL aclr_idle%0d got %b exp %b", i, o4, 7'b0); end
    end
    data_a = 4'h6; data_b = 4'h9; request_a = 1'b1; request_b = 1'b1;
    exp_q.push_back('{REQ_A, 8'h06});
    tick();
    request_a = 1'b0; request_b = 1'b0;
    checks++;
    if ({grant_a, grant_b} !== 2'b10) begin errors++; $display("FAIL aclr_grant got %b exp %b", {grant_a, grant_b}, 2'b10); end
    for (int i = 0; i < 5; i++) tick();
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || chain4 !== e.word[3:0]) begin
      errors++; $display("FAIL aclr_done got done=%b chain=%b exp done=1 chain=%b", done, chain4, e.word[3:0]);
    end
    tick();
  endtask

  task automatic test_width8();
    exp_t e;
    int nvalid, done_at;
    logic [7:0] bits;
    nvalid = 0; done_at = 0; bits = '0;
    data_b8 = 8'hA5; request_b8 = 1'b1;
    exp_q.push_back('{REQ_B, 8'hA5});
    for (int c = 1; c <= 14 && done_at == 0; c++) begin
      tick();
      if (c == 1) begin
        request_b8 = 1'b0;
        checks++;
        if ({grant_a8, grant_b8} !== 2'b01) begin errors++; $display("FAIL w8_grant got %b exp %b", {grant_a8, grant_b8}, 2'b01); end
      end
      if (chain_valid8) begin bits = {bits[6:0], chain_data8}; nvalid++; end
      if (done8) done_at = c;
    end
    e = exp_q.pop_front();
    checks++;
    if (nvalid != 8) begin errors++; $display("FAIL w8_nvalid got %0d exp %0d", nvalid, 8); end
    checks++;
    if (bits !== e.word) begin errors++; $display("FAIL w8_bits got %b exp %b", bits, e.word); end
    checks++;
    if (done_at != 10) begin errors++; $display("FAIL w8_done_cycle got %0d exp %0d", done_at, 10); end
    checks++;
    if (chain8 !== e.word) begin errors++; $display("FAIL w8_chain got %b exp %b", chain8, e.word); end
    tick();
  endtask

  initial begin
    test_reset();
    test_a_alone();
    test_back_to_back();
    test_ignore_b();
    test_data_change();
    test_async_clear();
    test_width8();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp %0d", exp_q.size(), 0); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
